siganfu_fire_arbiter: RTL and testbench

SIGANFU_FIRE_ARBITER -- requirements
Module: siganfu_fire_arbiter

---
 rtl/siganfu_fire_arbiter_if.sv | 20 ++
 rtl/siganfu_fire_arbiter.sv | 119 +++++++++++
 tb/tb_siganfu_fire_arbiter.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/siganfu_fire_arbiter_if.sv
// Console/gun bundle for the fire arbiter: three console request lanes plus gun control and status.
interface siganfu_fire_arbiter_if;
  logic [2:0] req, req_mode, req_enemy, req_locked;
  logic       gun_fire_trigger, gun_criticality_alert;
  logic       gun_target_locked, gun_is_enemy, gun_firing_mode, gun_fire_command;
  logic [2:0] grant, denied;
  logic [4:0] rounds_fired;
  logic [1:0] arb_state;

  modport master (
    output req, req_mode, req_enemy, req_locked, gun_fire_trigger, gun_criticality_alert,
    input  gun_target_locked, gun_is_enemy, gun_firing_mode, gun_fire_command,
           grant, denied, rounds_fired, arb_state
  );
  modport slave (
    input  req, req_mode, req_enemy, req_locked, gun_fire_trigger, gun_criticality_alert,
    output gun_target_locked, gun_is_enemy, gun_firing_mode, gun_fire_command,
           grant, denied, rounds_fired, arb_state
  );
endinterface

// File: rtl/siganfu_fire_arbiter.sv
// Round-robin arbiter giving one of three consoles control of a shared gun,
// with lock timeout, burst limiting, overheat hold and revocation on non-enemy targets.
module siganfu_fire_arbiter #(
  parameter int BURST_LIMIT  = 5,
  parameter int LOCK_TIMEOUT = 8
) (
  input logic                  sysclk,
  input logic                  reboot,
  siganfu_fire_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, FIRE = 2'd2, HOLD = 2'd3} state_t;
  localparam int WW = (LOCK_TIMEOUT < 2) ? 1 : $clog2(LOCK_TIMEOUT + 1);

  state_t        state, state_n;
  logic [1:0]    owner, owner_n, last_owner, last_n;
  logic [4:0]    rounds, rounds_n;
  logic [WW-1:0] wait_cnt, wait_n;
  logic [2:0]    denied_q, denied_n, own_oh;
  logic          active, release_c, req_g, en_g, lk_g, md_g, others;

  // Search order starts just after the previous owner.
  function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] lo);
    logic [1:0] a, b, c;
    case (lo)
      2'd0:    begin a = 2'd1; b = 2'd2; c = 2'd0; end
      2'd1:    begin a = 2'd2; b = 2'd0; c = 2'd1; end
      default: begin a = 2'd0; b = 2'd1; c = 2'd2; end
    endcase
    if (r[a])      return a;
    else if (r[b]) return b;
    else           return c;
  endfunction

  assign active = (state != IDLE);
  assign own_oh = 3'b001 << owner;
  assign req_g  = bus.req[owner];
  assign en_g   = bus.req_enemy[owner];
  assign lk_g   = bus.req_locked[owner];
  assign md_g   = bus.req_mode[owner];
  assign others = |(bus.req & ~own_oh);

  always_ff @(posedge sysclk) begin
    if (reboot) begin
      state      <= IDLE;
      owner      <= 2'd0;
      last_owner <= 2'd2;
      rounds     <= '0;
      wait_cnt   <= '0;
      denied_q   <= '0;
    end else begin
      state      <= state_n;
      owner      <= owner_n;
      last_owner <= last_n;
      rounds     <= rounds_n;
      wait_cnt   <= wait_n;
      denied_q   <= denied_n;
    end
  end

  always_comb begin
    state_n   = state;
    owner_n   = owner;
    last_n    = last_owner;
    rounds_n  = rounds;
    wait_n    = wait_cnt;
    denied_n  = '0;
    release_c = 1'b0;
    case (state)
      IDLE: if (|bus.req) begin
        state_n  = GRANT;
        owner_n  = rr_pick(bus.req, last_owner);
        rounds_n = '0;
        wait_n   = '0;
      end
      GRANT: begin
        if (!en_g) begin
          release_c = 1'b1;
          denied_n  = own_oh;
        end else if (!req_g) release_c = 1'b1;
        else if (lk_g) begin
          state_n = FIRE;
          wait_n  = '0;
        end else if (wait_cnt == WW'(LOCK_TIMEOUT - 1)) release_c = 1'b1;
        else wait_n = wait_cnt + 1'b1;
      end
      FIRE: begin
        // A trigger is counted even on the cycle the grant ends or overheats.
        if (bus.gun_fire_trigger && rounds != 5'd31) rounds_n = rounds + 5'd1;
        if (!en_g) begin
          release_c = 1'b1;
          denied_n  = own_oh;
        end else if (!req_g || !lk_g) release_c = 1'b1;
        else if (bus.gun_criticality_alert) state_n = HOLD;
        else if ((!md_g && rounds >= 5'd1) ||
                 (md_g && rounds >= 5'(BURST_LIMIT) && others)) release_c = 1'b1;
      end
      HOLD: begin
        if (!req_g) release_c = 1'b1;
        else if (!bus.gun_criticality_alert) state_n = GRANT;
      end
      default: state_n = IDLE;
    endcase
    if (release_c) begin
      state_n  = IDLE;
      rounds_n = '0;
      wait_n   = '0;
      last_n   = owner;
    end
  end

  assign bus.grant             = active ? own_oh : 3'b000;
  assign bus.denied            = denied_q;
  assign bus.rounds_fired      = rounds;
  assign bus.arb_state         = state;
  assign bus.gun_target_locked = active & lk_g;
  assign bus.gun_is_enemy      = active & en_g;
  assign bus.gun_firing_mode   = active & md_g;
  assign bus.gun_fire_command  = (state == FIRE);
endmodule

// File: tb/tb_siganfu_fire_arbiter.sv
// Directed bench for siganfu_fire_arbiter: a per-cycle vector table plus hand sequences
// for overheat hold and reboot during firing.
module tb_siganfu_fire_arbiter;
  logic sysclk = 1'b0;
  logic reboot = 1'b0;
  logic started = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  siganfu_fire_arbiter_if bus ();
  siganfu_fire_arbiter #(.BURST_LIMIT(5), .LOCK_TIMEOUT(8)) dut (
    .sysclk(sysclk), .reboot(reboot), .bus(bus)
  );

  always #5 sysclk = ~sysclk;

  typedef struct {
    logic       rst;
    logic [2:0] req, md, en, lk;
    logic       tr, al;
    logic [2:0] e_grant;
    logic [1:0] e_state;
    logic [3:0] e_gun;  // {locked, enemy, mode, fire_command}
    logic [4:0] e_rounds;
    logic [2:0] e_den;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic rst, input logic [2:0] req, md, en, lk, input logic tr, al,
                     input logic [2:0] eg, input logic [1:0] es, input logic [3:0] egun,
                     input logic [4:0] er, input logic [2:0] ed);
    vec_t v;
    v.rst = rst; v.req = req; v.md = md; v.en = en; v.lk = lk; v.tr = tr; v.al = al;
    v.e_grant = eg; v.e_state = es; v.e_gun = egun; v.e_rounds = er; v.e_den = ed;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic rst, input logic [2:0] r, md, en, lk, input logic tr, al);
    reboot = rst;
    bus.req = r; bus.req_mode = md; bus.req_enemy = en; bus.req_locked = lk;
    bus.gun_fire_trigger = tr; bus.gun_criticality_alert = al;
    @(posedge sysclk);
    #1;
    started = 1'b1;
  endtask

  function automatic logic [31:0] outs();
    return 32'({bus.grant, bus.arb_state, bus.gun_target_locked, bus.gun_is_enemy,
                bus.gun_firing_mode, bus.gun_fire_command, bus.rounds_fired, bus.denied});
  endfunction

  always @(negedge sysclk) begin
    if (started) begin
      check("grant_onehot0", 32'($onehot0(bus.grant)), 32'd1);
      if (bus.gun_fire_command) check("cmd_only_in_fire", 32'(bus.arb_state), 32'd2);
    end
  end

  initial begin
    bus.req = '0; bus.req_mode = '0; bus.req_enemy = '0; bus.req_locked = '0;
    bus.gun_fire_trigger = 1'b0; bus.gun_criticality_alert = 1'b0;

    // Reset, then a non-enemy request is granted and revoked with denied.
    add(1, 3'b000, 3'b000, 3'b000, 3'b000, 0, 0, 3'b000, 2'd0, 4'b0000, 5'd0, 3'b000);
    add(0, 3'b100, 3'b000, 3'b000, 3'b000, 0, 0, 3'b100, 2'd1, 4'b0000, 5'd0, 3'b000);
    add(0, 3'b100, 3'b000, 3'b000, 3'b000, 0, 0, 3'b000, 2'd0, 4'b0000, 5'd0, 3'b100);
    add(0, 3'b000, 3'b000, 3'b000, 3'b000, 0, 0, 3'b000, 2'd0, 4'b0000, 5'd0, 3'b000);
    // Lock never arrives: eight GRANT cycles, then release without denied.
    add(0, 3'b001, 3'b000, 3'b001, 3'b000, 0, 0, 3'b001, 2'd1, 4'b0100, 5'd0, 3'b000);
    for (int k = 0; k < 7; k++)
      add(0, 3'b001, 3'b000, 3'b001, 3'b000, 0, 0, 3'b001, 2'd1, 4'b0100, 5'd0, 3'b000);
    add(0, 3'b001, 3'b000, 3'b001, 3'b000, 0, 0, 3'b000, 2'd0, 4'b0000, 5'd0, 3'b000);
    add(0, 3'b000, 3'b000, 3'b000, 3'b000, 0, 0, 3'b000, 2'd0, 4'b0000, 5'd0, 3'b000);
    // Single mode: one round, then release.
    add(0, 3'b001, 3'b000, 3'b001, 3'b001, 0, 0, 3'b001, 2'd1, 4'b1100, 5'd0, 3'b000);
    add(0, 3'b001, 3'b000, 3'b001, 3'b001, 0, 0, 3'b001, 2'd2, 4'b1101, 5'd0, 3'b000);
    add(0, 3'b001, 3'b000, 3'b001, 3'b001, 1, 0, 3'b001, 2'd2, 4'b1101, 5'd1, 3'b000);
    add(0, 3'b001, 3'b000, 3'b001, 3'b001, 0, 0, 3'b000, 2'd0, 4'b0000, 5'd0, 3'b000);
    add(0, 3'b000, 3'b000, 3'b000, 3'b000, 0, 0, 3'b000, 2'd0, 4'b0000, 5'd0, 3'b000);
    // Two auto consoles: burst limit hands the gun from 0 to 1 after one IDLE cycle.
    add(1, 3'b000, 3'b000, 3'b000, 3'b000, 0, 0, 3'b000, 2'd0, 4'b0000, 5'd0, 3'b000);
    add(0, 3'b011, 3'b011, 3'b011, 3'b011, 0, 0, 3'b001, 2'd1, 4'b1110, 5'd0, 3'b000);
    add(0, 3'b011, 3'b011, 3'b011, 3'b011, 0, 0, 3'b001, 2'd2, 4'b1111, 5'd0, 3'b000);
    for (int k = 1; k <= 5; k++)
      add(0, 3'b011, 3'b011, 3'b011, 3'b011, 1, 0, 3'b001, 2'd2, 4'b1111, 5'(k), 3'b000);
    add(0, 3'b011, 3'b011, 3'b011, 3'b011, 0, 0, 3'b000, 2'd0, 4'b0000, 5'd0, 3'b000);
    add(0, 3'b011, 3'b011, 3'b011, 3'b011, 0, 0, 3'b010, 2'd1, 4'b1110, 5'd0, 3'b000);
    add(0, 3'b011, 3'b011, 3'b011, 3'b011, 0, 0, 3'b010, 2'd2, 4'b1111, 5'd0, 3'b000);
    add(0, 3'b000, 3'b011, 3'b011, 3'b011, 0, 0, 3'b000, 2'd0, 4'b0000, 5'd0, 3'b000);
    // Lone auto console runs past the burst limit and saturates at 31.
    add(1, 3'b000, 3'b000, 3'b000, 3'b000, 0, 0, 3'b000, 2'd0, 4'b0000, 5'd0, 3'b000);
    add(0, 3'b001, 3'b001, 3'b001, 3'b001, 0, 0, 3'b001, 2'd1, 4'b1110, 5'd0, 3'b000);
    add(0, 3'b001, 3'b001, 3'b001, 3'b001, 0, 0, 3'b001, 2'd2, 4'b1111, 5'd0, 3'b000);
    for (int k = 1; k <= 33; k++)
      add(0, 3'b001, 3'b001, 3'b001, 3'b001, 1, 0, 3'b001, 2'd2, 4'b1111,
          5'((k > 31) ? 31 : k), 3'b000);
    add(0, 3'b000, 3'b001, 3'b001, 3'b001, 0, 0, 3'b000, 2'd0, 4'b0000, 5'd0, 3'b000);
    // Enemy flag drops mid-FIRE: revoked with denied (owner 1 after owner 0).
    add(0, 3'b010, 3'b000, 3'b010, 3'b010, 0, 0, 3'b010, 2'd1, 4'b1100, 5'd0, 3'b000);
    add(0, 3'b010, 3'b000, 3'b010, 3'b010, 0, 0, 3'b010, 2'd2, 4'b1101, 5'd0, 3'b000);
    add(0, 3'b010, 3'b000, 3'b000, 3'b010, 0, 0, 3'b000, 2'd0, 4'b0000, 5'd0, 3'b010);
    add(0, 3'b000, 3'b000, 3'b000, 3'b000, 0, 0, 3'b000, 2'd0, 4'b0000, 5'd0, 3'b000);
    // Lock drops mid-FIRE: released without denied.
    add(0, 3'b100, 3'b100, 3'b100, 3'b100, 0, 0, 3'b100, 2'd1, 4'b1110, 5'd0, 3'b000);
    add(0, 3'b100, 3'b100, 3'b100, 3'b100, 0, 0, 3'b100, 2'd2, 4'b1111, 5'd0, 3'b000);
    add(0, 3'b100, 3'b100, 3'b100, 3'b000, 0, 0, 3'b000, 2'd0, 4'b0000, 5'd0, 3'b000);
    add(0, 3'b000, 3'b000, 3'b000, 3'b000, 0, 0, 3'b000, 2'd0, 4'b0000, 5'd0, 3'b000);

    foreach (tbl[i]) begin
      cyc(tbl[i].rst, tbl[i].req, tbl[i].md, tbl[i].en, tbl[i].lk, tbl[i].tr, tbl[i].al);
      check($sformatf("vec%0d", i), outs(),
            32'({tbl[i].e_grant, tbl[i].e_state, tbl[i].e_gun, tbl[i].e_rounds, tbl[i].e_den}));
    end

    // Overheat: HOLD keeps grant and count, trigger on the alert cycle still counts.
    cyc(1, 3'b000, 3'b000, 3'b000, 3'b000, 0, 0);
    cyc(0, 3'b001, 3'b001, 3'b001, 3'b001, 0, 0);
    cyc(0, 3'b001, 3'b001, 3'b001, 3'b001, 0, 0);
    repeat (3) cyc(0, 3'b001, 3'b001, 3'b001, 3'b001, 1, 0);
    check("pre_alert_rounds", 32'(bus.rounds_fired), 32'd3);
    cyc(0, 3'b001, 3'b001, 3'b001, 3'b001, 1, 1);
    check("alert_enter_hold", outs(), 32'({3'b001, 2'd3, 4'b1110, 5'd4, 3'b000}));
    for (int k = 0; k < 9; k++) cyc(0, 3'b001, 3'b001, 3'b001, 3'b001, k[0], 1);
    check("hold_kept", outs(), 32'({3'b001, 2'd3, 4'b1110, 5'd4, 3'b000}));
    cyc(0, 3'b001, 3'b001, 3'b001, 3'b001, 0, 0);
    check("alert_clear_grant", 32'(bus.arb_state), 32'd1);
    cyc(0, 3'b001, 3'b001, 3'b001, 3'b001, 0, 0);
    check("regrant_fire", outs(), 32'({3'b001, 2'd2, 4'b1111, 5'd4, 3'b000}));
    // Lock loss outranks alert in the same cycle.
    cyc(0, 3'b001, 3'b001, 3'b001, 3'b000, 0, 1);
    check("lockloss_over_alert", outs(), 32'd0);

    // Reboot mid-FIRE with seven rounds counted.
    cyc(1, 3'b000, 3'b000, 3'b000, 3'b000, 0, 0);
    cyc(0, 3'b001, 3'b001, 3'b001, 3'b001, 0, 0);
    cyc(0, 3'b001, 3'b001, 3'b001, 3'b001, 0, 0);
    repeat (7) cyc(0, 3'b001, 3'b001, 3'b001, 3'b001, 1, 0);
    check("rounds_seven", 32'(bus.rounds_fired), 32'd7);
    cyc(1, 3'b001, 3'b001, 3'b001, 3'b001, 1, 0);
    check("reboot_mid_fire", outs(), 32'd0);
    cyc(0, 3'b011, 3'b011, 3'b011, 3'b011, 0, 0);
    check("post_reboot_grant", 32'(bus.grant), 32'b001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
